// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg
//   Shared types and default sizing for the ram_loader block.
//   state_e : load FSM encoding (IDLE / LOAD / DONE)
//   DW, AW, DEPTH : default data width, address width, entry count
package ram_loader_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if
//   Bundles the byte-stream write side, the ROM-style read side and the
//   load status of ram_loader.
//   master : source/reader side (drives start, in_valid, in_data, addr)
//   slave  : ram_loader side (drives in_ready, dout, done, count, checksum)
interface ram_loader_if #(
    parameter int DW = ram_loader_pkg::DW,
    parameter int AW = ram_loader_pkg::AW
);
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          done;
    logic [AW:0]   count;
    logic [DW-1:0] checksum;

    modport master (
        output start, in_valid, in_data, addr,
        input  in_ready, dout, done, count, checksum
    );

    modport slave (
        input  start, in_valid, in_data, addr,
        output in_ready, dout, done, count, checksum
    );
endinterface

// File: rtl/ram_sp_1r1w.sv
// ram_sp_1r1w
//   DEPTH x DW storage, one write port and one registered read port.
//   clk_i, rst_i            : clock, async active-high reset (read register only)
//   we_i, waddr_i, wdata_i  : write port
//   raddr_i, rdata_o        : read port, one-cycle latency
//   A read of the address being written returns the old contents, since the
//   read register samples the array before the write lands.
module ram_sp_1r1w #(
    parameter int DW    = ram_loader_pkg::DW,
    parameter int AW    = ram_loader_pkg::AW,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    // Storage is deliberately not reset: contents survive rst and start.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_loader.sv
// ram_loader
//   16x8 memory loaded from a valid/ready byte stream at consecutive
//   addresses from 0, read back through a ROM-style addr -> registered dout
//   port.
//   clk : clock, rising edge
//   rst : async active-high reset
//   bus : ram_loader_if.slave (start, stream in, read port, done/count/checksum)
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DW    = ram_loader_pkg::DW,
    parameter int AW    = ram_loader_pkg::AW,
    parameter int DEPTH = 2 ** AW
) (
    input  logic           clk,
    input  logic           rst,
    ram_loader_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_LOAD = 2'(LOAD);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] csum_q,  csum_d;
    logic          accept;

    // start wins over a same-cycle byte, which is dropped.
    assign accept = bus.in_valid && (state_q == S_LOAD) && !bus.start;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        csum_d  = csum_q;
        if (bus.start) begin
            state_d = S_LOAD;
            count_d = '0;
            csum_d  = '0;
        end else if (accept) begin
            count_d = count_q + 1'b1;
            csum_d  = csum_q + bus.in_data;
            if (count_q == (AW+1)'(DEPTH - 1)) state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            csum_q  <= csum_d;
        end
    end

    // Write pointer is the low bits of count; count stops at DEPTH so it
    // never wraps.
    ram_sp_1r1w #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (accept),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (bus.in_data),
        .raddr_i (bus.addr),
        .rdata_o (bus.dout)
    );

    assign bus.in_ready = (state_q == S_LOAD);
    assign bus.done     = (state_q == S_DONE);
    assign bus.count    = count_q;
    assign bus.checksum = csum_q;
endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ram_loader_if #(.DW(8), .AW(4)) bus ();

    ram_loader #(.DW(8), .AW(4), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.addr = '0;

        // reset values
        repeat (3) tick();
        chk("rst_dout",  bus.dout, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_csum",  bus.checksum, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_ready", bus.in_ready, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'hAA;
        repeat (4) tick();
        chk("idle_ignore_count", bus.count, 0);
        chk("idle_ignore_csum",  bus.checksum, 0);
        bus.in_valid = 1'b0;

        // full load 0x10..0x1F
        pulse_start();
        chk("start_ready", bus.in_ready, 1);
        chk("start_count", bus.count, 0);
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h10 + i);
            tick();
            if (i == 14) chk("full_done_early", bus.done, 0);
        end
        bus.in_valid = 1'b0;
        chk("full_done",  bus.done, 1);
        chk("full_ready", bus.in_ready, 0);
        chk("full_count", bus.count, 16);
        chk("full_csum",  bus.checksum, 8'h78);
        for (int a = 0; a < 16; a++) begin
            bus.addr = 4'(a);
            tick();
            chk("full_rd", bus.dout, 8'h10 + a);
        end
        tick();
        chk("done_hold_count", bus.count, 16);

        // gapped load 0x01..0x10
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data = 8'(1 + i / 2);
            tick();
            if (i == 29) chk("gap_done_early", bus.done, 0);
            if (i == 30) chk("gap_done", bus.done, 1);
        end
        bus.in_valid = 1'b0;
        chk("gap_count", bus.count, 16);
        chk("gap_csum",  bus.checksum, 8'h88);
        for (int a = 0; a < 16; a++) begin
            bus.addr = 4'(a);
            tick();
            chk("gap_rd", bus.dout, a + 1);
        end

        // restart mid-load
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'hFF;
            tick();
        end
        chk("rs_count5", bus.count, 5);
        bus.start = 1'b1;
        bus.in_data = 8'h55;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        chk("rs_count0", bus.count, 0);
        chk("rs_csum0",  bus.checksum, 0);
        chk("rs_ready",  bus.in_ready, 1);
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("rs_done", bus.done, 1);
        chk("rs_csum", bus.checksum, 8'h78);
        for (int a = 0; a < 16; a++) begin
            bus.addr = 4'(a);
            tick();
            chk("rs_rd", bus.dout, a);
        end

        // read-during-write at address 3 (old value 0x03)
        bus.addr = 4'd3;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'hA0 + i);
            tick();
        end
        bus.in_data = 8'h3C;
        tick();
        bus.in_valid = 1'b0;
        chk("rdw_old", bus.dout, 8'h03);
        tick();
        chk("rdw_new", bus.dout, 8'h3C);

        // reset mid-load after 6 accepts
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h61 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("rm_count6", bus.count, 6);
        rst = 1'b1;
        #1;
        chk("rm_count", bus.count, 0);
        chk("rm_csum",  bus.checksum, 0);
        chk("rm_ready", bus.in_ready, 0);
        chk("rm_dout",  bus.dout, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rm_idle_ready", bus.in_ready, 0);
        pulse_start();
        for (int a = 0; a < 6; a++) begin
            bus.addr = 4'(a);
            tick();
            chk("rm_rd", bus.dout, 8'h61 + a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
